// File: rtl/mxwb_pkg_11.sv
// Shared definitions for the writeback queue: register-file load addresses,
// the FLAGS lane index and the address-to-lane decode used by the load decoder.
package mxwb_pkg_11;

  localparam int unsigned AddrW     = 8;
  localparam int unsigned MaskW     = 32;
  localparam int unsigned FlagsLane = 7;

  localparam logic [AddrW-1:0] AddrA      = 8'h00;
  localparam logic [AddrW-1:0] AddrB      = 8'h01;
  localparam logic [AddrW-1:0] AddrC      = 8'h02;
  localparam logic [AddrW-1:0] AddrD      = 8'h03;
  localparam logic [AddrW-1:0] AddrE      = 8'h04;
  localparam logic [AddrW-1:0] AddrH      = 8'h05;
  localparam logic [AddrW-1:0] AddrL      = 8'h06;
  localparam logic [AddrW-1:0] AddrF      = 8'h07;
  localparam logic [AddrW-1:0] AddrSp     = 8'h08;
  localparam logic [AddrW-1:0] AddrIx     = 8'h09;
  localparam logic [AddrW-1:0] AddrIy     = 8'h0A;
  localparam logic [AddrW-1:0] AddrPc     = 8'h0B;
  localparam logic [AddrW-1:0] AddrR0     = 8'h0C;
  localparam logic [AddrW-1:0] AddrR1     = 8'h0D;
  localparam logic [AddrW-1:0] AddrR2     = 8'h0E;
  localparam logic [AddrW-1:0] AddrR3     = 8'h0F;
  localparam logic [AddrW-1:0] AddrFlagsA = 8'h10;
  localparam logic [AddrW-1:0] AddrFlagsD = 8'h11;

  function automatic logic addr_legal(input logic [AddrW-1:0] addr);
    return addr <= AddrFlagsD;
  endfunction

  // Addresses whose write also updates the FLAGS lane with the flag value.
  function automatic logic uses_flags(input logic [AddrW-1:0] addr);
    return (addr == AddrF) || (addr == AddrFlagsA) || (addr == AddrFlagsD);
  endfunction

  // Lanes touched by a load at this address; combined addresses hit two lanes.
  function automatic logic [MaskW-1:0] lane_mask(input logic [AddrW-1:0] addr);
    logic [MaskW-1:0] m;
    m = '0;
    if (addr <= AddrR3) begin
      m[addr[3:0]] = 1'b1;
    end else if (addr == AddrFlagsA) begin
      m[0]         = 1'b1;
      m[FlagsLane] = 1'b1;
    end else if (addr == AddrFlagsD) begin
      m[3]         = 1'b1;
      m[FlagsLane] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mxwb_fifo_11.sv
// Write-queue storage: circular buffer with count-based full/empty, plus a
// view of every slot so the top can build the outstanding-lane mask.
module mxwb_fifo_11 #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [Depth-1:0]         slot_valid_o,
  output logic [Depth*Width-1:0]   slots_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;
  logic [PtrW-1:0]  offset;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers and occupancy; pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  // Entry storage; contents of unoccupied slots are don't-care.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    offset       = '0;
    slot_valid_o = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      offset          = PtrW'(i) - rd_ptr_q;
      slot_valid_o[i] = ({1'b0, offset} < count_q);
    end
  end

  for (genvar g = 0; g < int'(Depth); g++) begin : g_slots
    assign slots_o[g*Width +: Width] = mem_q[g];
  end

endmodule

// File: rtl/mxreg_writeback_11.sv
// Writeback queue in front of the register-file load decoder. Requests are
// queued, drained one per cycle into registered load outputs with per-lane
// steering of the flag value onto the FLAGS lane.
// Optional feature: define MXWB_SCOREBOARD_EN to drive pending_mask with the
// lanes that still have an outstanding write; otherwise pending_mask is 0.
module mxreg_writeback_11
  import mxwb_pkg_11::*;
#(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [7:0]                   wb_addr,
  input  logic [WORD_LENGTH-1:0]       wb_data,
  input  logic [WORD_LENGTH-1:0]       wb_flags,
  input  logic                         flush,
  output logic [7:0]                   load_addr,
  output logic                         load_en,
  output logic [DEPTH*WORD_LENGTH-1:0] data_line,
  output logic [DEPTH-1:0]             pending_mask,
  output logic [$clog2(QDEPTH):0]      q_count,
  output logic                         illegal_addr
);
  localparam int unsigned EntW = AddrW + 2 * WORD_LENGTH;

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e                       state_q;
  logic                         load_en_q, illegal_q;
  logic [AddrW-1:0]             load_addr_q;
  logic [DEPTH*WORD_LENGTH-1:0] data_line_q, line_d;

  logic                         push, pop, fifo_empty, fifo_full;
  logic [EntW-1:0]              wr_entry, head_entry;
  logic [AddrW-1:0]             head_addr;
  logic [WORD_LENGTH-1:0]       head_flags, head_data;
  logic [QDEPTH-1:0]            slot_valid;
  logic [QDEPTH*EntW-1:0]       slots;

  assign wb_ready = !fifo_full && !flush;
  assign push     = wb_valid && wb_ready && addr_legal(wb_addr);
  assign pop      = (state_q == StDrain) && !fifo_empty && !flush;
  assign wr_entry = {wb_addr, wb_flags, wb_data};

  assign head_addr  = head_entry[EntW-1 -: AddrW];
  assign head_flags = head_entry[2*WORD_LENGTH-1 -: WORD_LENGTH];
  assign head_data  = head_entry[WORD_LENGTH-1:0];

  mxwb_fifo_11 #(
    .Width (EntW),
    .Depth (QDEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (flush),
    .push_i       (push),
    .wdata_i      (wr_entry),
    .pop_i        (pop),
    .rdata_o      (head_entry),
    .count_o      (q_count),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .slot_valid_o (slot_valid),
    .slots_o      (slots)
  );

  // Lane steering: every lane carries the data, FLAGS lane carries flags when addressed.
  always_comb begin
    line_d = '0;
    for (int l = 0; l < int'(DEPTH); l++) begin
      line_d[l*WORD_LENGTH +: WORD_LENGTH] =
          (l == int'(FlagsLane) && uses_flags(head_addr)) ? head_flags : head_data;
    end
  end

  // Drain FSM with registered load outputs; outputs hold between pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      load_en_q   <= 1'b0;
      load_addr_q <= '0;
      data_line_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= wb_valid && wb_ready && !addr_legal(wb_addr);
      if (flush) begin
        state_q   <= StIdle;
        load_en_q <= 1'b0;
      end else begin
        load_en_q <= pop;
        if (pop) begin
          load_addr_q <= head_addr;
          data_line_q <= line_d;
        end
        unique case (state_q)
          StIdle:  if (push) state_q <= StDrain;
          StDrain: if (pop && !push && (q_count == ($clog2(QDEPTH)+1)'(1))) state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign load_en      = load_en_q;
  assign load_addr    = load_addr_q;
  assign data_line    = data_line_q;
  assign illegal_addr = illegal_q;

`ifdef MXWB_SCOREBOARD_EN
  logic [DEPTH-1:0] pend;

  // Outstanding lanes: every queued entry plus the entry on the outputs this cycle.
  always_comb begin
    pend = '0;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if (slot_valid[i]) pend |= DEPTH'(lane_mask(slots[i*EntW + 2*WORD_LENGTH +: AddrW]));
    end
    if (load_en_q) pend |= DEPTH'(lane_mask(load_addr_q));
  end

  assign pending_mask = pend;
`else
  assign pending_mask = '0;
`endif

  logic unused_slots;
  assign unused_slots = ^{slot_valid, slots};

endmodule

// File: tb/tb_mxreg_writeback_11.sv
// Randomised bench for mxreg_writeback_11 with a queue-based reference model
// and a scoreboard monitor sampling on the falling clock edge.
module tb_mxreg_writeback_11;
  localparam int WL = 8;
  localparam int DP = 16;
  localparam int QD = 4;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] flags;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb_valid = 1'b0;
  logic flush = 1'b0;
  logic [7:0] wb_addr = '0;
  logic [WL-1:0] wb_data = '0;
  logic [WL-1:0] wb_flags = '0;
  logic wb_ready, load_en, illegal_addr;
  logic [7:0] load_addr;
  logic [DP*WL-1:0] data_line;
  logic [DP-1:0] pending_mask;
  logic [2:0] q_count;

  mxreg_writeback_11 #(
    .WORD_LENGTH (WL),
    .DEPTH       (DP),
    .QDEPTH      (QD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_flags     (wb_flags),
    .flush        (flush),
    .load_addr    (load_addr),
    .load_en      (load_en),
    .data_line    (data_line),
    .pending_mask (pending_mask),
    .q_count      (q_count),
    .illegal_addr (illegal_addr)
  );

  always #5 clk = ~clk;

  ent_t mq[$];
  ent_t exp_q[$];
  ent_t mon_e;
  int nvec = 0;
  int nerr = 0;
  logic m_illegal = 1'b0;
  logic [DP-1:0] m_pend = '0;
  logic [DP-1:0] ep;
  logic [DP*WL-1:0] last_line = '0;
  logic [7:0] last_addr = '0;
  bit mon_en = 1'b0;

  function automatic logic [DP-1:0] lanes_of(input logic [7:0] a);
    logic [DP-1:0] one;
    one = 1;
    if (a < 8'h10) return one << a;
    if (a == 8'h10) return 16'h0081;
    if (a == 8'h11) return 16'h0088;
    return '0;
  endfunction

  function automatic logic [DP*WL-1:0] line_of(input ent_t e);
    logic [DP*WL-1:0] r;
    bool_flags: begin end
    r = '0;
    for (int l = 0; l < DP; l++) begin
      if (l == 7 && (e.addr == 8'h07 || e.addr == 8'h10 || e.addr == 8'h11))
        r[l*WL +: WL] = e.flags;
      else
        r[l*WL +: WL] = e.data;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    exp_q.delete();
    m_illegal = 1'b0;
    m_pend    = '0;
    last_line = '0;
    last_addr = '0;
  endtask

  // Advance the reference by one clock edge using the inputs the DUT just saw.
  task automatic model_step();
    int pre;
    bit acc, popped;
    ent_t e, n;
    pre = mq.size();
    popped = 1'b0;
    if (flush) begin
      mq.delete();
      m_illegal = 1'b0;
      m_pend = '0;
      return;
    end
    acc = wb_valid && (pre < QD);
    m_illegal = acc && (wb_addr > 8'h11);
    if (pre > 0) begin
      e = mq.pop_front();
      exp_q.push_back(e);
      popped = 1'b1;
    end
    if (acc && wb_addr <= 8'h11) begin
      n.addr = wb_addr;
      n.data = wb_data;
      n.flags = wb_flags;
      mq.push_back(n);
    end
    m_pend = popped ? lanes_of(e.addr) : '0;
    foreach (mq[i]) m_pend |= lanes_of(mq[i].addr);
  endtask

  task automatic apply(input bit v, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] f, input bit fl);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    wb_flags = f;
    flush    = fl;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  // Scoreboard monitor: every falling edge, compare status and any load pulse.
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef MXWB_SCOREBOARD_EN
      ep = m_pend;
`else
      ep = '0;
`endif
      chk("q_count", q_count, mq.size());
      chk("wb_ready", wb_ready, (mq.size() < QD) && !flush);
      chk("illegal_addr", illegal_addr, m_illegal);
      chk("pending_mask", pending_mask, ep);
      if (load_en) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL load_en: unexpected pulse, load_addr %0h, expected none", load_addr);
        end else begin
          mon_e = exp_q.pop_front();
          last_addr = mon_e.addr;
          last_line = line_of(mon_e);
          chk("load_addr", load_addr, last_addr);
          chk("data_line", data_line, last_line);
        end
      end else begin
        if (exp_q.size() != 0) begin
          nvec++;
          nerr++;
          $display("FAIL load_en: got 0, expected pulse for addr %0h", exp_q[0].addr);
          exp_q.delete();
        end
        chk("held load_addr", load_addr, last_addr);
        chk("held data_line", data_line, last_line);
      end
    end
  end

  initial begin
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset load_en", load_en, 1'b0);
    chk("reset q_count", q_count, 0);
    chk("reset load_addr", load_addr, 8'h00);
    chk("reset data_line", data_line, '0);
    chk("reset pending_mask", pending_mask, '0);
    chk("reset illegal_addr", illegal_addr, 1'b0);
    #2 rst = 1'b0;
    mon_en = 1'b1;

    // Single write into an empty queue.
    apply(1'b1, 8'h02, 8'h5A, 8'h00, 1'b0);
    idle(3);

    // Five back-to-back writes.
    for (int i = 0; i < 5; i++) apply(1'b1, 8'(8 + i), 8'(8'h10 + i), 8'h00, 1'b0);
    idle(3);

    // Combined flags write.
    apply(1'b1, 8'h10, 8'h33, 8'h81, 1'b0);
    idle(3);
    apply(1'b1, 8'h07, 8'h44, 8'hC3, 1'b0);
    apply(1'b1, 8'h11, 8'h55, 8'h3C, 1'b0);
    idle(3);

    // Illegal address is dropped.
    apply(1'b1, 8'h12, 8'hAA, 8'h00, 1'b0);
    idle(3);

    // Flush while a request is presented.
    apply(1'b1, 8'h03, 8'h01, 8'h00, 1'b0);
    apply(1'b1, 8'h04, 8'h02, 8'h00, 1'b0);
    apply(1'b1, 8'h05, 8'h03, 8'h00, 1'b1);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 4) != 0, 8'($urandom_range(0, 8'h13)), 8'($urandom),
            8'($urandom), ($urandom % 12) == 0);
    end
    idle(3);

    // Reset asserted off-edge while draining.
    apply(1'b1, 8'h0A, 8'h66, 8'h00, 1'b0);
    apply(1'b1, 8'h0B, 8'h77, 8'h00, 1'b0);
    wb_valid = 1'b0;
    #2 rst = 1'b1;
    reset_model();
    #1;
    chk("midreset load_en", load_en, 1'b0);
    chk("midreset q_count", q_count, 0);
    chk("midreset load_addr", load_addr, 8'h00);
    chk("midreset data_line", data_line, '0);
    chk("midreset illegal_addr", illegal_addr, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    idle(5);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
